instr_fetch_unit: RTL and testbench



---
 rtl/instr_fetch_unit.sv | 122 ++++++++++++
 tb/tb_instr_fetch_unit.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: RV32I fetch front end with one outstanding imem request,
// a DEPTH-entry instruction FIFO and redirect-driven flush.
`default_nettype none

module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned DEPTH    = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] instr_pc
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_DROP = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [31:0]   req_pc_q, req_pc_d;
    logic [CW-1:0] count_q, count_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic          live_q;
    logic [31:0]   mem_instr_q [DEPTH];
    logic [31:0]   mem_pc_q    [DEPTH];

    logic w_req;
    logic w_take;
    logic w_push;
    logic w_pop;
    logic w_unused_pc_lo;

    assign w_unused_pc_lo = &redirect_pc[1:0];

    // live_q keeps imem_req low for the cycle in which reset is still held
    assign w_req    = live_q && (state_q == S_REQ) && (count_q < DEPTH_C);
    assign w_take   = w_req && imem_gnt;
    assign w_push   = (state_q == S_WAIT) && imem_rvalid && !redirect;
    assign w_pop    = instr_valid && instr_ready && !redirect;

    assign imem_req    = w_req;
    assign imem_addr   = fetch_pc_q;
    assign instr_valid = (count_q != '0);
    assign instr       = instr_valid ? mem_instr_q[rd_ptr_q] : 32'h0;
    assign instr_pc    = instr_valid ? mem_pc_q[rd_ptr_q]    : 32'h0;

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        req_pc_d   = req_pc_q;
        count_d    = count_q + CW'(w_push) - CW'(w_pop);
        rd_ptr_d   = w_pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
        wr_ptr_d   = w_push ? wr_ptr_q + PW'(1) : wr_ptr_q;

        if (w_take) begin
            req_pc_d   = fetch_pc_q;
            fetch_pc_d = fetch_pc_q + 32'd4;
        end

        case (state_q)
            S_REQ:   state_d = w_take ? (redirect ? S_DROP : S_WAIT) : S_REQ;
            S_WAIT:  state_d = imem_rvalid ? S_REQ : (redirect ? S_DROP : S_WAIT);
            S_DROP:  state_d = imem_rvalid ? S_REQ : S_DROP;
            default: state_d = S_REQ;
        endcase

        if (redirect) begin
            fetch_pc_d = {redirect_pc[31:2], 2'b00};
            count_d    = '0;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= S_REQ;
            fetch_pc_q <= RESET_PC;
            req_pc_q   <= RESET_PC;
            count_q    <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            live_q     <= 1'b0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_instr_q[i] <= 32'h0;
                mem_pc_q[i]    <= 32'h0;
            end
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            req_pc_q   <= req_pc_d;
            count_q    <= count_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            live_q     <= 1'b1;
            if (w_push) begin
                mem_instr_q[wr_ptr_q] <= imem_rdata;
                mem_pc_q[wr_ptr_q]    <= req_pc_q;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: cycle-by-cycle directed vectors for instr_fetch_unit.
`default_nettype none

module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;

    int pass_cnt  = 0;
    int total_cnt = 0;

    instr_fetch_unit #(.RESET_PC(32'h0), .DEPTH(2)) dut (
        .clk         (clk),
        .reset       (reset),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr       (instr),
        .instr_pc    (instr_pc)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        gnt;
        logic        rv;
        logic [31:0] rdata;
        logic        rdr;
        logic [31:0] rpc;
        logic        rdy;
        logic        ereq;
        logic [31:0] eaddr;
        logic        eval;
        logic [31:0] epc;
        logic [31:0] eins;
    } vec_t;

    vec_t tbl[$];

    function automatic logic [31:0] dat(input logic [31:0] a);
        return a ^ 32'hA5A5A5A5;
    endfunction

    function automatic vec_t v(input logic rst, input logic gnt, input logic rv,
                               input logic [31:0] rdata, input logic rdr,
                               input logic [31:0] rpc, input logic rdy,
                               input logic ereq, input logic [31:0] eaddr,
                               input logic eval, input logic [31:0] epc,
                               input logic [31:0] eins);
        vec_t r;
        r.rst = rst; r.gnt = gnt; r.rv = rv; r.rdata = rdata; r.rdr = rdr;
        r.rpc = rpc; r.rdy = rdy; r.ereq = ereq; r.eaddr = eaddr;
        r.eval = eval; r.epc = epc; r.eins = eins;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act !== exp)
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        else
            pass_cnt++;
    endtask

    // Inputs change on the falling edge; outputs reflect state from the last rising edge.
    task automatic apply(input vec_t x, input string name);
        @(negedge clk);
        reset       = x.rst;
        imem_gnt    = x.gnt;
        imem_rvalid = x.rv;
        imem_rdata  = x.rdata;
        redirect    = x.rdr;
        redirect_pc = x.rpc;
        instr_ready = x.rdy;
        #1;
        chk({name, ".req"},   {31'h0, imem_req},    {31'h0, x.ereq});
        chk({name, ".addr"},  imem_addr,            x.eaddr);
        chk({name, ".valid"}, {31'h0, instr_valid}, {31'h0, x.eval});
        chk({name, ".pc"},    instr_pc,             x.epc);
        chk({name, ".instr"}, instr,                x.eins);
    endtask

    initial begin
        reset = 1'b0; imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
        redirect = 1'b0; redirect_pc = 32'h0; instr_ready = 1'b0;
        repeat (2) @(posedge clk);

        // Streaming fetch with immediate gnt and 1-cycle rvalid
        tbl.push_back(v(0,0,0,0,0,0,0, 0,0,0,0,0));
        tbl.push_back(v(1,0,0,0,0,0,0, 0,0,0,0,0));
        tbl.push_back(v(1,1,0,0,0,0,1, 1,0,0,0,0));
        tbl.push_back(v(1,0,1,dat(0),0,0,1, 0,4,0,0,0));
        tbl.push_back(v(1,1,0,0,0,0,1, 1,4,1,0,dat(0)));
        tbl.push_back(v(1,0,1,dat(4),0,0,1, 0,8,0,0,0));
        tbl.push_back(v(1,1,0,0,0,0,1, 1,8,1,4,dat(4)));
        tbl.push_back(v(1,0,1,dat(8),0,0,1, 0,'hC,0,0,0));
        tbl.push_back(v(1,1,0,0,0,0,1, 1,'hC,1,8,dat(8)));
        tbl.push_back(v(1,0,1,dat('hC),0,0,1, 0,'h10,0,0,0));
        tbl.push_back(v(1,0,0,0,0,0,1, 1,'h10,1,'hC,dat('hC)));
        // Back-pressure: fill both entries, gnt ignored while full, drain in order
        tbl.push_back(v(0,0,0,0,0,0,0, 1,'h10,0,0,0));
        tbl.push_back(v(1,0,0,0,0,0,0, 0,0,0,0,0));
        tbl.push_back(v(1,1,0,0,0,0,0, 1,0,0,0,0));
        tbl.push_back(v(1,0,1,dat(0),0,0,0, 0,4,0,0,0));
        tbl.push_back(v(1,1,0,0,0,0,0, 1,4,1,0,dat(0)));
        tbl.push_back(v(1,0,1,dat(4),0,0,0, 0,8,1,0,dat(0)));
        tbl.push_back(v(1,1,0,0,0,0,0, 0,8,1,0,dat(0)));
        tbl.push_back(v(1,0,0,0,0,0,0, 0,8,1,0,dat(0)));
        tbl.push_back(v(1,0,0,0,0,0,1, 0,8,1,0,dat(0)));
        tbl.push_back(v(1,1,0,0,0,0,1, 1,8,1,4,dat(4)));
        tbl.push_back(v(1,0,1,dat(8),0,0,1, 0,'hC,0,0,0));
        tbl.push_back(v(1,0,0,0,0,0,1, 1,'hC,1,8,dat(8)));

        foreach (tbl[i]) apply(tbl[i], $sformatf("row%0d", i));

        // Redirect while waiting; late response is dropped
        apply(v(1,1,0,0,0,0,1, 1,'hC,0,0,0), "rdw1");
        apply(v(1,0,0,0,1,'h100,1, 0,'h10,0,0,0), "rdw2");
        apply(v(1,0,0,0,0,0,1, 0,'h100,0,0,0), "rdw3");
        apply(v(1,0,0,0,0,0,1, 0,'h100,0,0,0), "rdw4");
        apply(v(1,0,1,32'hDEADBEEF,0,0,1, 0,'h100,0,0,0), "rdw5");
        apply(v(1,1,0,0,0,0,1, 1,'h100,0,0,0), "rdw6");
        apply(v(1,0,1,dat('h100),0,0,0, 0,'h104,0,0,0), "rdw7");
        apply(v(1,0,0,0,0,0,0, 1,'h104,1,'h100,dat('h100)), "rdw8");

        // Redirect coincident with gnt: orphaned request, unaligned target
        apply(v(1,1,0,0,1,'h203,0, 1,'h104,1,'h100,dat('h100)), "rdg1");
        apply(v(1,0,0,0,0,0,0, 0,'h200,0,0,0), "rdg2");
        apply(v(1,0,1,dat('h104),0,0,0, 0,'h200,0,0,0), "rdg3");
        apply(v(1,1,0,0,0,0,0, 1,'h200,0,0,0), "rdg4");
        apply(v(1,0,1,dat('h200),0,0,0, 0,'h204,0,0,0), "rdg5");
        apply(v(1,1,0,0,0,0,0, 1,'h204,1,'h200,dat('h200)), "rdg6");
        apply(v(1,0,1,dat('h204),0,0,0, 0,'h208,1,'h200,dat('h200)), "rdg7");

        // Redirect with stray rvalid and pop while two entries are buffered
        apply(v(1,0,1,32'h12345678,1,'h300,1, 0,'h208,1,'h200,dat('h200)), "rdf1");
        apply(v(1,0,0,0,0,0,1, 1,'h300,0,0,0), "rdf2");
        apply(v(1,1,0,0,0,0,1, 1,'h300,0,0,0), "rdf3");
        apply(v(1,0,1,dat('h300),0,0,0, 0,'h304,0,0,0), "rdf4");
        apply(v(1,0,0,0,0,0,1, 1,'h304,1,'h300,dat('h300)), "rdf5");

        // One-cycle reset mid-WAIT followed by an orphaned rvalid
        apply(v(1,1,0,0,0,0,1, 1,'h304,0,0,0), "rst1");
        apply(v(0,0,0,0,0,0,1, 0,'h308,0,0,0), "rst2");
        apply(v(1,0,1,dat('h304),0,0,1, 0,0,0,0,0), "rst3");
        apply(v(1,1,0,0,0,0,1, 1,0,0,0,0), "rst4");
        apply(v(1,0,1,dat(0),0,0,1, 0,4,0,0,0), "rst5");
        apply(v(1,0,0,0,0,0,1, 1,4,1,0,dat(0)), "rst6");

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

`default_nettype wire
